// File: rtl/seq_div_16bit_if.sv
// ----------------------------------------------------------------------------
// seq_div_16bit_if
// Start/done handshake bundle between a requester and the sequential divider.
//   start       requester -> divider  request, sampled on the rising edge
//   dividend    requester -> divider  numerator, captured on accept
//   divisor     requester -> divider  denominator, captured on accept
//   busy        divider -> requester  division in progress
//   done        divider -> requester  one-cycle completion pulse
//   quotient    divider -> requester  result, held until the next completion
//   remainder   divider -> requester  result, held until the next completion
//   div_by_zero divider -> requester  divisor was zero, held with the results
// ----------------------------------------------------------------------------
interface seq_div_16bit_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_div_16bit.sv
// ----------------------------------------------------------------------------
// seq_div_16bit
// Multi-cycle restoring divider, one quotient bit per clock. Each step is a
// trial subtraction r + ~divisor + 1 whose carry-out means "no borrow".
// Optional feature macro: SEQ_DIV_SIGNED_EN (two's complement operands,
// truncating toward zero; remainder follows the dividend sign).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; aborts any division in flight
//   bus  seq_div_16bit_if.slave handshake (start/operands in, results out)
// ----------------------------------------------------------------------------
module seq_div_16bit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   seq_div_16bit_if.slave    bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_accept;

   // Operand / iteration registers
   logic [WIDTH-1:0]   r_dvd_sh;     // dividend magnitude, shifted out MSB first
   logic [WIDTH-1:0]   r_dvs;        // divisor magnitude
   logic [WIDTH-1:0]   r_part;       // partial remainder (always < divisor)
   logic [WIDTH-2:0]   r_q_work;     // quotient bits resolved so far
   logic [CNT_W-1:0]   r_cnt;

   // Output registers
   logic               r_busy;
   logic               r_done;
   logic               r_dbz;
   logic [WIDTH-1:0]   r_quot;
   logic [WIDTH-1:0]   r_rem;

`ifdef SEQ_DIV_SIGNED_EN
   logic [WIDTH-1:0]   r_dvd_raw;    // original dividend, returned on divide by zero
   logic               r_neg_q;
   logic               r_neg_r;
`endif

   // Iteration datapath
   logic [WIDTH:0]     w_shift;
   logic [WIDTH+1:0]   w_trial;
   logic               w_no_borrow;
   logic [WIDTH-1:0]   w_r_next;
   logic [WIDTH-1:0]   w_q_mag;
   logic               w_dvs_zero;
   logic               w_last;

   // Accept-side operand conditioning and completion-side result fix-up
   logic [WIDTH-1:0]   w_dvd_in;
   logic [WIDTH-1:0]   w_dvs_in;
   logic [WIDTH-1:0]   w_q_fin;
   logic [WIDTH-1:0]   w_r_fin;
   logic [WIDTH-1:0]   w_dbz_rem;

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_dvs_zero || w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // One restoring step: shift in next dividend bit, trial-subtract divisor
   always_comb begin
      w_shift     = {r_part, r_dvd_sh[WIDTH-1]};
      w_trial     = {1'b0, w_shift} + {1'b0, ~{1'b0, r_dvs}} + (WIDTH + 2)'(1);
      // Bit WIDTH of the difference is clear whenever there is no borrow,
      // since the partial remainder stays below the divisor between steps.
      w_no_borrow = w_trial[WIDTH+1] & ~w_trial[WIDTH];
      w_r_next    = w_no_borrow ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_q_mag     = {r_q_work, w_no_borrow};
      w_dvs_zero  = (r_dvs == '0);
      w_last      = (r_cnt == CNT_W'(WIDTH - 1));
   end

`ifdef SEQ_DIV_SIGNED_EN
   // Magnitudes in, signs restored on completion
   always_comb begin
      w_dvd_in  = bus.dividend[WIDTH-1] ? WIDTH'(~bus.dividend + WIDTH'(1)) : bus.dividend;
      w_dvs_in  = bus.divisor[WIDTH-1]  ? WIDTH'(~bus.divisor  + WIDTH'(1)) : bus.divisor;
      w_q_fin   = r_neg_q ? WIDTH'(~w_q_mag  + WIDTH'(1)) : w_q_mag;
      w_r_fin   = r_neg_r ? WIDTH'(~w_r_next + WIDTH'(1)) : w_r_next;
      w_dbz_rem = r_dvd_raw;
   end
`else
   // Unsigned: operands and results pass straight through
   always_comb begin
      w_dvd_in  = bus.dividend;
      w_dvs_in  = bus.divisor;
      w_q_fin   = w_q_mag;
      w_r_fin   = w_r_next;
      w_dbz_rem = r_dvd_sh;   // not yet shifted on the single zero-divisor RUN cycle
   end
`endif

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dvd_sh  <= '0;
         r_dvs     <= '0;
         r_part    <= '0;
         r_q_work  <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_dbz     <= 1'b0;
         r_quot    <= '0;
         r_rem     <= '0;
`ifdef SEQ_DIV_SIGNED_EN
         r_dvd_raw <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
`endif
      end else begin
         r_busy <= (w_state_nxt == S_RUN);
         r_done <= (r_state == S_RUN) && (w_state_nxt == S_DONE);
         if (w_accept) begin
            r_dvd_sh  <= w_dvd_in;
            r_dvs     <= w_dvs_in;
            r_part    <= '0;
            r_q_work  <= '0;
            r_cnt     <= '0;
            r_dbz     <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            r_dvd_raw <= bus.dividend;
            r_neg_q   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg_r   <= bus.dividend[WIDTH-1];
`endif
         end else if (r_state == S_RUN) begin
            if (w_dvs_zero) begin
               r_dbz  <= 1'b1;
               r_quot <= '1;
               r_rem  <= w_dbz_rem;
            end else begin
               r_part   <= w_r_next;
               r_q_work <= w_q_mag[WIDTH-2:0];
               r_dvd_sh <= {r_dvd_sh[WIDTH-2:0], 1'b0};
               r_cnt    <= r_cnt + CNT_W'(1);
               // Results are published only on the final step
               if (w_last) begin
                  r_quot <= w_q_fin;
                  r_rem  <= w_r_fin;
               end
            end
         end
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_rem;
   assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_div_16bit.sv
// ----------------------------------------------------------------------------
// tb_seq_div_16bit
// Self-checking bench for seq_div_16bit: directed vectors, ignored start,
// back-to-back random divisions, and reset abort, all against a plain
// arithmetic reference model. Define SEQ_DIV_SIGNED_EN for the signed build.
// ----------------------------------------------------------------------------
module tb_seq_div_16bit;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned N_RND = 1000;

   logic clk = 1'b0;
   logic rst;

   int n_checks = 0;
   int n_errors = 0;

   seq_div_16bit_if #(.WIDTH(WIDTH)) bus ();

   seq_div_16bit #(.WIDTH(WIDTH)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain arithmetic on the operands
   function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] q, output logic [15:0] r);
`ifdef SEQ_DIV_SIGNED_EN
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      if (b == 16'h0) begin
         q = 16'hFFFF;
         r = a;
      end else begin
         q = 16'(sa / sb);
         r = 16'(sa % sb);
      end
`else
      if (b == 16'h0) begin
         q = 16'hFFFF;
         r = a;
      end else begin
         q = a / b;
         r = a % b;
      end
`endif
   endfunction

   // Single division from an idle divider, with latency and hold checks
   task automatic run_div(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] eq;
      logic [15:0] er;
      logic [15:0] q_before;
      int          lat;
      int          moved;
      ref_div(a, b, eq, er);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_after_accept", 32'(bus.busy), 32'd1);
      q_before = bus.quotient;
      lat      = 0;
      moved    = 0;
      while (!bus.done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (!bus.done && bus.quotient !== q_before) moved = 1;
      end
      chk("latency", 32'(lat), (b == 16'h0) ? 32'd1 : 32'd16);
      chk("quotient", 32'(bus.quotient), 32'(eq));
      chk("remainder", 32'(bus.remainder), 32'(er));
      chk("div_by_zero", 32'(bus.div_by_zero), (b == 16'h0) ? 32'd1 : 32'd0);
      chk("busy_at_done", 32'(bus.busy), 32'd0);
      chk("no_partial_update", 32'(moved), 32'd0);
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("result_hold", 32'(bus.quotient), 32'(eq));
   endtask

   logic [15:0] vec_a [$];
   logic [15:0] vec_b [$];
   logic [15:0] rnd_a [N_RND];
   logic [15:0] rnd_b [N_RND];

   initial begin
      logic [15:0] eq;
      logic [15:0] er;
      int          gap;
      int          seen;

      rst          = 1'b1;
      bus.start    = 1'b1;   // reset must dominate start
      bus.dividend = 16'd9;
      bus.divisor  = 16'd2;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_quotient", 32'(bus.quotient), 32'd0);
      chk("rst_remainder", 32'(bus.remainder), 32'd0);
      chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
      bus.start = 1'b0;
      rst       = 1'b0;

      // Directed vectors
      vec_a = '{16'd100, 16'hFFFF, 16'd3,  16'h1234, 16'hFFFF, 16'd0, 16'h8000, 16'd7};
      vec_b = '{16'd7,   16'd1,    16'd10, 16'h0000, 16'hFFFF, 16'd5, 16'd3,    16'd7};
`ifdef SEQ_DIV_SIGNED_EN
      vec_a.push_back(16'hFFF9); vec_b.push_back(16'd2);
      vec_a.push_back(16'h8000); vec_b.push_back(16'hFFFF);
      vec_a.push_back(16'd7);    vec_b.push_back(16'hFFFE);
      vec_a.push_back(16'h8001); vec_b.push_back(16'h0000);
`endif
      foreach (vec_a[i]) run_div(vec_a[i], vec_b[i]);

      // start pulses during RUN must not disturb the division in flight
      ref_div(16'd1000, 16'd7, eq, er);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 16'd1000;
      bus.divisor  = 16'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 16'd5;
      bus.divisor  = 16'd1;
      repeat (2) @(negedge clk);
      bus.start = 1'b0;
      gap = 6;
      while (!bus.done && gap < 40) begin
         @(negedge clk);
         gap++;
      end
      chk("ign_latency", 32'(gap), 32'd16);
      chk("ign_quotient", 32'(bus.quotient), 32'(eq));
      chk("ign_remainder", 32'(bus.remainder), 32'(er));
      repeat (2) @(negedge clk);

      // Back-to-back random divisions with start held high
      for (int i = 0; i < int'(N_RND); i++) begin
         rnd_a[i] = 16'($urandom);
         rnd_b[i] = 16'($urandom);
         case ($urandom_range(0, 9))
            0:       rnd_b[i] = 16'h0000;
            1, 2:    rnd_b[i] = rnd_b[i] & 16'h000F;
            3, 4:    rnd_b[i] = rnd_b[i] & 16'h00FF;
            default: ;
         endcase
      end
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = rnd_a[0];
      bus.divisor  = rnd_b[0];
      for (int i = 0; i < int'(N_RND); i++) begin
         gap = 0;
         do begin
            @(negedge clk);
            gap++;
         end while (!bus.done && gap < 40);
         ref_div(rnd_a[i], rnd_b[i], eq, er);
         chk("b2b_period", 32'(gap), (rnd_b[i] == 16'h0) ? 32'd2 : 32'(WIDTH + 1));
         chk("b2b_quotient", 32'(bus.quotient), 32'(eq));
         chk("b2b_remainder", 32'(bus.remainder), 32'(er));
         chk("b2b_dbz", 32'(bus.div_by_zero), (rnd_b[i] == 16'h0) ? 32'd1 : 32'd0);
         if (i + 1 < int'(N_RND)) begin
            bus.dividend = rnd_a[i+1];
            bus.divisor  = rnd_b[i+1];
         end else begin
            bus.start = 1'b0;
         end
      end
      repeat (2) @(negedge clk);

      // Make sure the held results are non-zero so the reset clear is visible
      run_div(16'd12345, 16'd100);

      // Reset in the middle of a run aborts it with no done pulse
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 16'd500;
      bus.divisor  = 16'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_quotient", 32'(bus.quotient), 32'd0);
      chk("abort_remainder", 32'(bus.remainder), 32'd0);
      chk("abort_dbz", 32'(bus.div_by_zero), 32'd0);
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done) seen = 1;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
      run_div(16'd500, 16'd3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
